// File: rtl/oldland_issue_pkg.sv
// Shared decode constants and helpers for the oldland issue stage.
// Provides instruction class codes, field positions and a use decoder.
package oldland_issue_pkg;

  localparam int SEL_W     = 3;
  localparam int RD_LSB    = 0;
  localparam int RA_LSB    = 3;
  localparam int RB_LSB    = 6;
  localparam int LOAD_BIT  = 29;
  localparam int CLASS_LSB = 30;

  localparam logic [1:0] CLASS_ALU    = 2'b00;
  localparam logic [1:0] CLASS_BRANCH = 2'b01;
  localparam logic [1:0] CLASS_LDST   = 2'b10;
  localparam logic [1:0] CLASS_MISC   = 2'b11;

  typedef struct packed {
    logic reads_a;
    logic reads_b;
    logic writes_rd;
  } uses_t;

  function automatic uses_t decode_uses(input logic [31:0] instr);
    uses_t u;
    u = '0;
    case (instr[CLASS_LSB +: 2])
      CLASS_ALU: begin
        u.reads_a   = 1'b1;
        u.reads_b   = 1'b1;
        u.writes_rd = 1'b1;
      end
      CLASS_BRANCH: begin
        u.reads_a = 1'b1;
      end
      CLASS_LDST: begin
        u.reads_a   = 1'b1;
        u.reads_b   = !instr[LOAD_BIT];
        u.writes_rd = instr[LOAD_BIT];
      end
      default: u = '0;
    endcase
    return u;
  endfunction

endpackage

// File: rtl/oldland_issue_if.sv
// Fetch-to-issue and issue-to-execute handshake bundle.
// slave: issue stage; master: fetch/execute side driving it.
interface oldland_issue_if;

  logic        fetch_valid;
  logic [31:0] fetch_instr;
  logic [31:0] fetch_pc;
  logic        fetch_stall;
  logic        iss_valid;
  logic [31:0] iss_instr;
  logic [31:0] iss_pc;
  logic [2:0]  iss_rd_sel;
  logic        iss_wr_rd;
  logic        iss_ready;
  logic        flush;

  modport slave (
    input  fetch_valid, fetch_instr, fetch_pc,
    input  iss_ready, flush,
    output fetch_stall,
    output iss_valid, iss_instr, iss_pc,
    output iss_rd_sel, iss_wr_rd
  );

  modport master (
    output fetch_valid, fetch_instr, fetch_pc,
    output iss_ready, flush,
    input  fetch_stall,
    input  iss_valid, iss_instr, iss_pc,
    input  iss_rd_sel, iss_wr_rd
  );

endinterface

// File: rtl/oldland_scoreboard.sv
// Per-register pending-write counters and hazard query.
// Ports: inc/wb/flush updates, two source + one dest query, hazard, idle.
module oldland_scoreboard
  import oldland_issue_pkg::*;
#(
  parameter int PEND_W = 2,
  parameter int NREGS  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_en,
  input  logic [SEL_W-1:0] inc_rd,
  input  logic             wb_en,
  input  logic [SEL_W-1:0] wb_rd,
  input  logic             fl_en,
  input  logic [SEL_W-1:0] fl_rd,
  input  logic             qa_en,
  input  logic [SEL_W-1:0] qa,
  input  logic             qb_en,
  input  logic [SEL_W-1:0] qb,
  input  logic             qd_en,
  input  logic [SEL_W-1:0] qd,
  output logic             hazard,
  output logic             idle
);

  localparam int SW = PEND_W + 2;
  localparam logic [PEND_W-1:0] MAX = '1;
  localparam logic [PEND_W-1:0] ONE = PEND_W'(1);

  logic [PEND_W-1:0] pend [NREGS];
  logic [PEND_W-1:0] nxt  [NREGS];
  logic [SW-1:0]     sum  [NREGS];
  logic [NREGS-1:0]  inc_v, wb_v, fl_v;
  logic [NREGS-1:0]  under, busy, full, zero;

  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      inc_v[r] = inc_en && (inc_rd == SEL_W'(r));
      wb_v[r]  = wb_en && (wb_rd == SEL_W'(r));
      fl_v[r]  = fl_en && (fl_rd == SEL_W'(r));
      sum[r]   = {2'b00, pend[r]} + SW'(inc_v[r])
               - SW'(wb_v[r]) - SW'(fl_v[r]);
      // Top bit only sets on a net decrement below zero.
      under[r] = sum[r][SW-1];
      nxt[r]   = under[r] ? '0 : sum[r][PEND_W-1:0];
      // A single pending write landing this cycle is bypassed.
      busy[r]  = (pend[r] > ONE)
              || ((pend[r] == ONE) && !wb_v[r]);
      full[r]  = (pend[r] == MAX);
      zero[r]  = (pend[r] == '0);
    end
  end

  always_ff @(posedge clk) begin
    for (int r = 0; r < NREGS; r++) begin
      if (!rst_n) pend[r] <= '0;
      else        pend[r] <= nxt[r];
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) assert (under == '0);
  end

  assign hazard = (qa_en && busy[qa])
               || (qb_en && busy[qb])
               || (qd_en && full[qd]);
  assign idle = &zero;

endmodule

// File: rtl/oldland_issue.sv
// Decode/issue stage: regfile selects, issue register, hazard stall.
// Ports: clk, rst_n, bus (fetch/issue handshake), ra/rb_sel, wb, debug.
module oldland_issue
  import oldland_issue_pkg::*;
#(
  parameter int PEND_W = 2,
  parameter int NREGS  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  oldland_issue_if.slave    bus,
  output logic [SEL_W-1:0]  ra_sel,
  output logic [SEL_W-1:0]  rb_sel,
  input  logic              wb_en,
  input  logic [SEL_W-1:0]  wb_rd,
  input  logic              dbg_en,
  output logic              dbg_idle
);

  uses_t            use_f;
  logic [SEL_W-1:0] f_rd, f_ra, f_rb;
  logic             hazard, idle, accept;
  logic             fl_en;

  assign use_f = decode_uses(bus.fetch_instr);
  assign f_rd  = bus.fetch_instr[RD_LSB +: SEL_W];
  assign f_ra  = bus.fetch_instr[RA_LSB +: SEL_W];
  assign f_rb  = bus.fetch_instr[RB_LSB +: SEL_W];

  assign accept = rst_n && bus.fetch_valid && !hazard
               && !dbg_en && !bus.flush
               && (!bus.iss_valid || bus.iss_ready);

  assign bus.fetch_stall = !rst_n
                        || (bus.fetch_valid && !accept);

  // Held instructions keep re-reading their operands.
  assign ra_sel = accept ? f_ra
                : bus.iss_instr[RA_LSB +: SEL_W];
  assign rb_sel = accept ? f_rb
                : bus.iss_instr[RB_LSB +: SEL_W];

  assign fl_en = bus.flush && bus.iss_valid
              && bus.iss_wr_rd;

  oldland_scoreboard #(
    .PEND_W (PEND_W),
    .NREGS  (NREGS)
  ) u_sb (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc_en (accept && use_f.writes_rd),
    .inc_rd (f_rd),
    .wb_en  (wb_en),
    .wb_rd  (wb_rd),
    .fl_en  (fl_en),
    .fl_rd  (bus.iss_rd_sel),
    .qa_en  (use_f.reads_a),
    .qa     (f_ra),
    .qb_en  (use_f.reads_b),
    .qb     (f_rb),
    .qd_en  (use_f.writes_rd),
    .qd     (f_rd),
    .hazard (hazard),
    .idle   (idle)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.iss_valid  <= 1'b0;
      bus.iss_instr  <= '0;
      bus.iss_pc     <= '0;
      bus.iss_rd_sel <= '0;
      bus.iss_wr_rd  <= 1'b0;
    end else if (accept) begin
      bus.iss_valid  <= 1'b1;
      bus.iss_instr  <= bus.fetch_instr;
      bus.iss_pc     <= bus.fetch_pc;
      bus.iss_rd_sel <= f_rd;
      bus.iss_wr_rd  <= use_f.writes_rd;
    end else if (bus.iss_ready || bus.flush) begin
      bus.iss_valid  <= 1'b0;
    end
  end

  assign dbg_idle = idle && !bus.iss_valid;

endmodule
